// File: rtl/const_divmod_pipe.sv
// Exact divide-by-constant pipeline: reciprocal multiply, one correction step,
// optional floored signed division. Four register stages with a global stall.
module const_divmod_pipe #(
  parameter int unsigned     WIDTH   = 32,
  parameter longint unsigned DIVISOR = 100,
  parameter bit              SIGNED  = 1'b1,
  parameter int unsigned     TAG_W   = 8,
  parameter int unsigned     RW      = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [RW-1:0]    out_rem,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned     RW1     = RW + 1;
  localparam longint unsigned DIV_MAX = (64'd1 << (WIDTH - 1)) - 64'd1;
  localparam logic [WIDTH:0]  POW2    = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] M      = WIDTH'(POW2 / (WIDTH + 1)'(DIVISOR));
  localparam logic [WIDTH-1:0] DIV_W  = WIDTH'(DIVISOR);
  localparam logic [RW1-1:0]   DIV_R  = RW1'(DIVISOR);

  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("const_divmod_pipe: WIDTH %0d outside 8..64", WIDTH);
  end
  if (DIVISOR < 2 || DIVISOR > DIV_MAX) begin : g_bad_divisor
    $error("const_divmod_pipe: DIVISOR %0d outside 2..2^(WIDTH-1)-1", DIVISOR);
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("const_divmod_pipe: TAG_W must be at least 1");
  end
  if (RW != $clog2(DIVISOR)) begin : g_bad_rw
    $error("const_divmod_pipe: RW is derived from DIVISOR and must not be overridden");
  end

  logic en;

  logic             s1_valid, s1_neg;
  logic [WIDTH-1:0] s1_mag;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid, s2_neg;
  logic [WIDTH-1:0] s2_mag, s2_q0;
  logic [TAG_W-1:0] s2_tag;

  logic             s3_valid, s3_neg;
  logic [WIDTH-1:0] s3_q0;
  logic [RW1-1:0]   s3_r0;
  logic [TAG_W-1:0] s3_tag;

  logic             in_neg_c;
  logic [WIDTH-1:0] in_mag_c;
  logic [WIDTH-1:0] q0_c;
  logic [RW1-1:0]   r0_c;
  logic             corr_c;
  logic [WIDTH-1:0] q1_c, quot_c;
  logic [RW-1:0]    r1_c, rem_c;

  // A full output register that is not being taken stalls every stage.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // S1 magnitude; negating the most negative value wraps to 2^(WIDTH-1), as wanted.
  always_comb begin
    in_neg_c = SIGNED && in_data[WIDTH-1];
    in_mag_c = in_neg_c ? -in_data : in_data;
  end

  // S2/S3 estimate: q0 is the true quotient or one less.
  always_comb begin
    q0_c = WIDTH'(({{WIDTH{1'b0}}, s1_mag} * {{WIDTH{1'b0}}, M}) >> WIDTH);
    r0_c = RW1'(s2_mag - s2_q0 * DIV_W);
  end

  // S4 correction, then floor adjustment for negative dividends.
  always_comb begin
    corr_c = (s3_r0 >= DIV_R);
    q1_c   = s3_q0 + WIDTH'(corr_c);
    r1_c   = RW'(corr_c ? (s3_r0 - DIV_R) : s3_r0);
    quot_c = q1_c;
    rem_c  = r1_c;
    if (s3_neg) begin
      if (r1_c == '0) begin
        quot_c = -q1_c;
      end else begin
        quot_c = ~q1_c;
        rem_c  = RW'(DIV_R - {1'b0, r1_c});
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_neg    <= 1'b0;
      s1_mag    <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_neg    <= 1'b0;
      s2_mag    <= '0;
      s2_q0     <= '0;
      s2_tag    <= '0;
      s3_valid  <= 1'b0;
      s3_neg    <= 1'b0;
      s3_q0     <= '0;
      s3_r0     <= '0;
      s3_tag    <= '0;
      out_valid <= 1'b0;
      out_quot  <= '0;
      out_rem   <= '0;
      out_tag   <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_neg    <= in_neg_c;
      s1_mag    <= in_mag_c;
      s1_tag    <= in_tag;
      s2_valid  <= s1_valid;
      s2_neg    <= s1_neg;
      s2_mag    <= s1_mag;
      s2_q0     <= q0_c;
      s2_tag    <= s1_tag;
      s3_valid  <= s2_valid;
      s3_neg    <= s2_neg;
      s3_q0     <= s2_q0;
      s3_r0     <= r0_c;
      s3_tag    <= s2_tag;
      out_valid <= s3_valid;
      out_quot  <= quot_c;
      out_rem   <= rem_c;
      out_tag   <= s3_tag;
    end
  end

endmodule

// File: tb/tb_const_divmod_pipe.sv
// Bench for const_divmod_pipe: three instances (signed/100, unsigned/100, 16-bit/7)
// share stimulus and are scoreboarded against a floored-division reference.
module tb_const_divmod_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0]  in_tag;

  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [31:0] q0o, q1o;
  logic [15:0] q2o;
  logic [6:0]  r0o, r1o;
  logic [2:0]  r2o;
  logic [7:0]  t0o, t1o, t2o;

  always #5 clk = ~clk;

  const_divmod_pipe #(.WIDTH(32), .DIVISOR(100), .SIGNED(1'b1), .TAG_W(8)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .in_tag(in_tag), .out_valid(ov0), .out_ready(out_ready), .out_quot(q0o),
    .out_rem(r0o), .out_tag(t0o));

  const_divmod_pipe #(.WIDTH(32), .DIVISOR(100), .SIGNED(1'b0), .TAG_W(8)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready), .out_quot(q1o),
    .out_rem(r1o), .out_tag(t1o));

  const_divmod_pipe #(.WIDTH(16), .DIVISOR(7), .SIGNED(1'b0), .TAG_W(8)) u_dut_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data[15:0]),
    .in_tag(in_tag), .out_valid(ov2), .out_ready(out_ready), .out_quot(q2o),
    .out_rem(r2o), .out_tag(t2o));

  typedef struct {
    logic [63:0] data;
    logic [7:0]  tag;
    int          cyc;
  } exp_t;

  exp_t sb0[$], sb1[$], sb2[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_out[3];
  bit          lat_chk = 1'b0;
  bit          acc[3];
  bit          stall_prev[3];
  bit          saw_stall;
  logic [63:0] pq[3];
  longint      pr[3];
  logic [7:0]  pt[3];

  function automatic int dw(input int k);
    return (k == 2) ? 16 : 32;
  endfunction

  function automatic longint dd(input int k);
    return (k == 2) ? 64'sd7 : 64'sd100;
  endfunction

  function automatic bit ds(input int k);
    return (k == 0);
  endfunction

  // Interpret the low w bits of raw as the dividend value of instance k.
  function automatic longint sext(input logic [63:0] raw, input int k);
    longint n;
    int     w;
    w = dw(k);
    n = longint'(raw & ((64'd1 << w) - 64'd1));
    if (ds(k) && raw[w-1]) n = n - (longint'(1) << w);
    return n;
  endfunction

  task automatic ref_div(input logic [63:0] raw, input int k,
                         output logic [63:0] q, output longint r);
    longint n, d, qq;
    n  = sext(raw, k);
    d  = dd(k);
    qq = n / d;
    r  = n % d;
    if (r < 0) begin
      qq = qq - 1;
      r  = r + d;
    end
    q = 64'(qq) & ((64'd1 << dw(k)) - 64'd1);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int sb_size(input int k);
    case (k)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic pop_check(input int k, input logic [63:0] q_got, input longint r_got,
                           input logic [7:0] t_got);
    exp_t        e;
    logic [63:0] eq;
    longint      er;
    case (k)
      0:       e = sb0.pop_front();
      1:       e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
    n_out[k]++;
    ref_div(e.data, k, eq, er);
    check($sformatf("quot[%0d]", k), q_got, eq);
    check($sformatf("rem[%0d]", k), r_got, er);
    check($sformatf("tag[%0d]", k), t_got, e.tag);
    check($sformatf("invariant[%0d]", k),
          64'(sext(q_got, k) * dd(k) + r_got == sext(e.data, k)), 64'd1);
    check($sformatf("rem_range[%0d]", k), 64'(r_got >= 0 && r_got < dd(k)), 64'd1);
    if (lat_chk) check($sformatf("latency[%0d]", k), 64'(cyc - e.cyc), 64'd4);
  endtask

  task automatic observe(input int k, input logic ir, input logic ov,
                         input logic [63:0] q, input longint r, input logic [7:0] tg);
    exp_t e;
    check($sformatf("in_ready[%0d]", k), 64'(ir), 64'(!(ov && !out_ready)));
    if (stall_prev[k]) begin
      check($sformatf("hold_valid[%0d]", k), 64'(ov), 64'd1);
      check($sformatf("hold_quot[%0d]", k), q, pq[k]);
      check($sformatf("hold_rem[%0d]", k), r, pr[k]);
      check($sformatf("hold_tag[%0d]", k), 64'(tg), 64'(pt[k]));
      if (k == 0) saw_stall = 1'b1;
    end
    if (ov && sb_size(k) == 0) check($sformatf("spurious_valid[%0d]", k), 64'(ov), 64'd0);
    else if (ov && out_ready) pop_check(k, q, r, tg);
    acc[k] = in_valid && ir;
    if (acc[k]) begin
      e.data = 64'(in_data);
      e.tag  = in_tag;
      e.cyc  = cyc;
      case (k)
        0:       sb0.push_back(e);
        1:       sb1.push_back(e);
        default: sb2.push_back(e);
      endcase
    end
    stall_prev[k] = ov && !out_ready;
    pq[k] = q;
    pr[k] = r;
    pt[k] = tg;
  endtask

  task automatic step(input bit v, input logic [31:0] d, input logic [7:0] t, input bit ordy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_tag    = t;
    out_ready = ordy;
    #1;
    cyc++;
    observe(0, ir0, ov0, 64'(q0o), longint'(r0o), t0o);
    observe(1, ir1, ov1, 64'(q1o), longint'(r1o), t1o);
    observe(2, ir2, ov2, 64'(q2o), longint'(r2o), t2o);
  endtask

  task automatic clear_sb();
    sb0.delete();
    sb1.delete();
    sb2.delete();
    for (int k = 0; k < 3; k++) stall_prev[k] = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom % 8)
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom % 300);
      4:       return -32'($urandom % 300);
      5:       return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] words[6];
    logic [31:0] dir_a[4];
    logic [31:0] dir_b[4];
    int          idx, base;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_out[k] = 0; stall_prev[k] = 1'b0; acc[k] = 1'b0;
    end
    saw_stall = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 64'({ov0, ov1, ov2}), 64'd0);
    check("reset_quot", 64'(q0o), 64'd0);
    check("reset_rem", 64'(r0o), 64'd0);
    check("reset_tag", 64'(t0o), 64'd0);
    rst = 1'b0;
    step(1'b0, '0, '0, 1'b1);
    check("reset_in_ready", 64'({ir0, ir1, ir2}), 64'h7);

    // Back-to-back stream, including the correction case 100.
    dir_a = '{32'd1234, 32'd99, 32'd100, 32'd0};
    dir_b = '{32'hFFFF_FFFF, -32'sd200, 32'h8000_0000, 32'hFFFF_FFFF};
    lat_chk = 1'b1;
    base = n_out[0];
    for (int i = 0; i < 4; i++) step(1'b1, dir_a[i], 8'(i + 1), 1'b1);
    repeat (6) step(1'b0, '0, '0, 1'b1);
    check("stream_count", 64'(n_out[0] - base), 64'd4);

    // Negative operands and the most negative value; tags must come back in order.
    base = n_out[0];
    for (int i = 0; i < 4; i++) step(1'b1, dir_b[i], 8'(8'h11 * (i + 1)), 1'b1);
    repeat (6) step(1'b0, '0, '0, 1'b1);
    check("signed_count", 64'(n_out[0] - base), 64'd4);
    lat_chk = 1'b0;

    // Backpressure: downstream refuses for the first 9 cycles.
    for (int i = 0; i < 6; i++) words[i] = rand_word();
    base = n_out[0];
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      step(idx < 6, (idx < 6) ? words[idx] : 32'h0, 8'(8'hA0 + idx), c >= 9);
      if (acc[0]) idx++;
      if (idx == 6 && sb0.size() == 0) break;
    end
    check("bp_all_accepted", 64'(idx), 64'd6);
    check("bp_count", 64'(n_out[0] - base), 64'd6);
    check("bp_stall_seen", 64'(saw_stall), 64'd1);

    // Asynchronous reset between clock edges with words in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(5000 + i), 8'(8'hC0 + i), 1'b1);
    step(1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_valid", 64'(ov0), 64'd1);
    rst = 1'b1;
    #1;
    check("async_reset_valid", 64'({ov0, ov1, ov2}), 64'd0);
    check("async_reset_quot", 64'(q0o), 64'd0);
    check("async_reset_tag", 64'(t0o), 64'd0);
    clear_sb();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = n_out[0];
    repeat (6) step(1'b0, '0, '0, 1'b1);
    lat_chk = 1'b1;
    step(1'b1, -32'sd777, 8'h5A, 1'b1);
    repeat (6) step(1'b0, '0, '0, 1'b1);
    lat_chk = 1'b0;
    check("post_reset_count", 64'(n_out[0] - base), 64'd1);

    // Random traffic with random valid/ready on both sides.
    for (int i = 0; i < 10000; i++)
      step(($urandom % 4) != 0, rand_word(), 8'($urandom), ($urandom % 4) != 0);
    for (int i = 0; i < 100; i++) begin
      if (sb0.size() == 0 && sb1.size() == 0 && sb2.size() == 0) break;
      step(1'b0, '0, '0, 1'b1);
    end
    check("drain_sb0", 64'(sb0.size()), 64'd0);
    check("drain_sb1", 64'(sb1.size()), 64'd0);
    check("drain_sb2", 64'(sb2.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
